// File: rtl/vga_timing_if.sv
// vga_timing_if - raster timing bundle between the timing generator and the
// pixel/colour logic.
//   pix_en      : pixel strobe into the generator
//   x, y        : current raster position
//   active      : (x,y) lies in the visible area
//   hs, vs      : syncs aligned with x / y
//   line_start  : one-cycle pulse when x becomes 0
//   frame_start : one-cycle pulse when (x,y) becomes (0,0)
//   frame_count : completed frame starts, wrapping
//   hs_d, vs_d, blank_d : syncs and !active delayed to match the pixel pipe
// Modports: master = timing generator, slave = pixel/colour logic.
interface vga_timing_if #(
    parameter int CW      = 10,
    parameter int FRAME_W = 8
);
    logic               pix_en;
    logic [CW-1:0]      x;
    logic [CW-1:0]      y;
    logic               active;
    logic               hs;
    logic               vs;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_count;
    logic               hs_d;
    logic               vs_d;
    logic               blank_d;

    modport master (
        input  pix_en,
        output x, y, active, hs, vs, line_start, frame_start, frame_count,
        output hs_d, vs_d, blank_d
    );

    modport slave (
        output pix_en,
        input  x, y, active, hs, vs, line_start, frame_start, frame_count,
        input  hs_d, vs_d, blank_d
    );
endinterface

// File: rtl/vga_timing.sv
// vga_timing - parametrised raster timing generator.
// Counts x/y on every pix_en strobe, decodes active/hs/vs for the same pixel
// as x/y, emits line/frame start markers and a frame counter, and delays
// {hs, vs, !active} by PIPE strobes for a pipelined pixel generator.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   vga   : vga_timing_if master (pix_en in; position, syncs, markers out)
module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int PIPE      = 1,
    parameter int CW        = 10,
    parameter int FRAME_W   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_timing_if.master  vga
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    generate
        if ((((H_TOTAL - 1) >> CW) != 0) || (((V_TOTAL - 1) >> CW) != 0)
            || (PIPE < 0) || (PIPE > 7)) begin : g_bad_cfg
            $error("vga_timing: CW too narrow for totals or PIPE outside 0..7");
        end
    endgenerate

    logic [CW-1:0]      x_q, x_d;
    logic [CW-1:0]      y_q, y_d;
    logic               act_q, act_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               lstart_q, lstart_d;
    logic               fstart_q, fstart_d;
    logic [FRAME_W-1:0] fcnt_q, fcnt_d;
    logic               x_wrap;

    // Decode from the next position so the registered flags describe the
    // same pixel as the registered x/y.
    always_comb begin
        x_wrap   = (x_q == CW'(H_TOTAL - 1));
        x_d      = x_wrap ? '0 : x_q + CW'(1);
        y_d      = y_q;
        if (x_wrap) begin
            y_d = (y_q == CW'(V_TOTAL - 1)) ? '0 : y_q + CW'(1);
        end
        act_d    = (int'(x_d) < H_VISIBLE) && (int'(y_d) < V_VISIBLE);
        hsync_d  = ((int'(x_d) >= HS_START) && (int'(x_d) < HS_END)) ? HS_POL : !HS_POL;
        vsync_d  = ((int'(y_d) >= VS_START) && (int'(y_d) < VS_END)) ? VS_POL : !VS_POL;
        lstart_d = x_wrap;
        fstart_d = x_wrap && (y_d == '0);
        fcnt_d   = fstart_d ? fcnt_q + FRAME_W'(1) : fcnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q      <= CW'(H_TOTAL - 1);
            y_q      <= CW'(V_TOTAL - 1);
            act_q    <= 1'b0;
            hsync_q  <= !HS_POL;
            vsync_q  <= !VS_POL;
            lstart_q <= 1'b0;
            fstart_q <= 1'b0;
            fcnt_q   <= '0;
        end else if (vga.pix_en) begin
            x_q      <= x_d;
            y_q      <= y_d;
            act_q    <= act_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            lstart_q <= lstart_d;
            fstart_q <= fstart_d;
            fcnt_q   <= fcnt_d;
        end else begin
            lstart_q <= 1'b0;
            fstart_q <= 1'b0;
        end
    end

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.active      = act_q;
    assign vga.hs          = hsync_q;
    assign vga.vs          = vsync_q;
    assign vga.line_start  = lstart_q;
    assign vga.frame_start = fstart_q;
    assign vga.frame_count = fcnt_q;

    // Delay line advances on strobes only, so the lag is PIPE pixels
    // regardless of the pix_en duty cycle.
    generate
        if (PIPE == 0) begin : g_nodly
            assign vga.hs_d    = hsync_q;
            assign vga.vs_d    = vsync_q;
            assign vga.blank_d = !act_q;
        end else begin : g_dly
            localparam int unsigned DEPTH = PIPE;
            logic [2:0] dly_q [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        dly_q[i] <= {!HS_POL, !VS_POL, 1'b1};
                    end
                end else if (vga.pix_en) begin
                    dly_q[0] <= {hsync_q, vsync_q, !act_q};
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign {vga.hs_d, vga.vs_d, vga.blank_d} = dly_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing - directed bench for vga_timing. Four instances share one
// clock, reset and strobe: defaults (PIPE=1), defaults with PIPE=3 and
// PIPE=0, and a tiny 7x6 raster with HS_POL=1 and a 2-bit frame counter.
// Expected values come from strobe counting: after n strobes since reset the
// position is (n-1) mod H_TOTAL on line ((n-1) div H_TOTAL) mod V_TOTAL.
module tb_vga_timing;
    typedef struct {
        int hv, hf, hsy, hb;
        int vv, vf, vsy, vb;
        bit hpol, vpol;
        int fw, pipe;
    } cfg_t;

    typedef struct {
        int x, y;
        bit act, hs, vs;
        int fc;
    } exp_t;

    localparam cfg_t CFG_D  = '{hv:640, hf:16, hsy:96, hb:48, vv:480, vf:10, vsy:2, vb:33,
                                hpol:1'b0, vpol:1'b0, fw:8, pipe:1};
    localparam cfg_t CFG_P3 = '{hv:640, hf:16, hsy:96, hb:48, vv:480, vf:10, vsy:2, vb:33,
                                hpol:1'b0, vpol:1'b0, fw:8, pipe:3};
    localparam cfg_t CFG_P0 = '{hv:640, hf:16, hsy:96, hb:48, vv:480, vf:10, vsy:2, vb:33,
                                hpol:1'b0, vpol:1'b0, fw:8, pipe:0};
    localparam cfg_t CFG_S  = '{hv:4, hf:1, hsy:1, hb:1, vv:3, vf:1, vsy:1, vb:1,
                                hpol:1'b1, vpol:1'b0, fw:2, pipe:1};

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en;

    always #5 clk = ~clk;

    vga_timing_if #(.CW(10), .FRAME_W(8)) if_d  ();
    vga_timing_if #(.CW(10), .FRAME_W(8)) if_p3 ();
    vga_timing_if #(.CW(10), .FRAME_W(8)) if_p0 ();
    vga_timing_if #(.CW(4),  .FRAME_W(2)) if_s  ();

    assign if_d.pix_en  = pix_en;
    assign if_p3.pix_en = pix_en;
    assign if_p0.pix_en = pix_en;
    assign if_s.pix_en  = pix_en;

    vga_timing #(.PIPE(1)) u_d  (.clk(clk), .rst_n(rst_n), .vga(if_d));
    vga_timing #(.PIPE(3)) u_p3 (.clk(clk), .rst_n(rst_n), .vga(if_p3));
    vga_timing #(.PIPE(0)) u_p0 (.clk(clk), .rst_n(rst_n), .vga(if_p0));
    vga_timing #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .PIPE(1), .CW(4), .FRAME_W(2)
    ) u_s (.clk(clk), .rst_n(rst_n), .vga(if_s));

    int vec_cnt = 0;
    int err_cnt = 0;
    int n       = 0;      // strobes since reset release
    bit last_en = 1'b0;   // previous edge was a strobe out of reset
    int cyc     = 0;
    int ls_per  = 0;      // expected line period of u_d, 0 = not measured
    int sf_per  = 0;      // expected frame period of u_s, 0 = not measured
    int last_ls = -1;
    int last_fs = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, strobe %0d)", tag, got, exp, cyc, n);
        end
    endtask

    function automatic exp_t exp_at(input cfg_t c, input int k);
        exp_t e;
        int ht, vt, p;
        ht = c.hv + c.hf + c.hsy + c.hb;
        vt = c.vv + c.vf + c.vsy + c.vb;
        if (k <= 0) begin
            e.x = ht - 1; e.y = vt - 1; e.act = 1'b0;
            e.hs = !c.hpol; e.vs = !c.vpol; e.fc = 0;
        end else begin
            p     = k - 1;
            e.x   = p % ht;
            e.y   = (p / ht) % vt;
            e.act = (e.x < c.hv) && (e.y < c.vv);
            e.hs  = (e.x >= c.hv + c.hf && e.x < c.hv + c.hf + c.hsy) ? c.hpol : !c.hpol;
            e.vs  = (e.y >= c.vv + c.vf && e.y < c.vv + c.vf + c.vsy) ? c.vpol : !c.vpol;
            e.fc  = ((p / (ht * vt)) + 1) % (1 << c.fw);
        end
        return e;
    endfunction

    task automatic check_inst(input string nm, input cfg_t c,
                              input logic [31:0] x, input logic [31:0] y,
                              input logic act, input logic hs, input logic vs,
                              input logic ls, input logic fs, input logic [31:0] fc,
                              input logic hsd, input logic vsd, input logic bld);
        exp_t e, d;
        bit   els;
        e   = exp_at(c, n);
        d   = exp_at(c, n - c.pipe);
        els = last_en && (n > 0) && (e.x == 0);
        check({nm, ".x"},           x,          32'(e.x));
        check({nm, ".y"},           y,          32'(e.y));
        check({nm, ".active"},      32'(act),   32'(e.act));
        check({nm, ".hs"},          32'(hs),    32'(e.hs));
        check({nm, ".vs"},          32'(vs),    32'(e.vs));
        check({nm, ".line_start"},  32'(ls),    32'(els));
        check({nm, ".frame_start"}, 32'(fs),    32'(els && (e.y == 0)));
        check({nm, ".frame_count"}, fc,         32'(e.fc));
        check({nm, ".hs_d"},        32'(hsd),   32'(d.hs));
        check({nm, ".vs_d"},        32'(vsd),   32'(d.vs));
        check({nm, ".blank_d"},     32'(bld),   32'(!d.act));
    endtask

    // One clock: drive, wait for the edge, sample 1 ns later, compare.
    task automatic step(input logic rn, input logic en);
        rst_n  = rn;
        pix_en = en;
        @(posedge clk);
        #1;
        cyc++;
        if (!rn) begin
            n = 0; last_en = 1'b0;
        end else if (en) begin
            n++; last_en = 1'b1;
        end else begin
            last_en = 1'b0;
        end
        check_inst("D", CFG_D, 32'(if_d.x), 32'(if_d.y), if_d.active, if_d.hs, if_d.vs,
                   if_d.line_start, if_d.frame_start, 32'(if_d.frame_count),
                   if_d.hs_d, if_d.vs_d, if_d.blank_d);
        check_inst("P3", CFG_P3, 32'(if_p3.x), 32'(if_p3.y), if_p3.active, if_p3.hs, if_p3.vs,
                   if_p3.line_start, if_p3.frame_start, 32'(if_p3.frame_count),
                   if_p3.hs_d, if_p3.vs_d, if_p3.blank_d);
        check_inst("P0", CFG_P0, 32'(if_p0.x), 32'(if_p0.y), if_p0.active, if_p0.hs, if_p0.vs,
                   if_p0.line_start, if_p0.frame_start, 32'(if_p0.frame_count),
                   if_p0.hs_d, if_p0.vs_d, if_p0.blank_d);
        check_inst("S", CFG_S, 32'(if_s.x), 32'(if_s.y), if_s.active, if_s.hs, if_s.vs,
                   if_s.line_start, if_s.frame_start, 32'(if_s.frame_count),
                   if_s.hs_d, if_s.vs_d, if_s.blank_d);
        if (if_d.line_start) begin
            if (ls_per > 0 && last_ls >= 0) check("D.line_period", 32'(cyc - last_ls), 32'(ls_per));
            last_ls = cyc;
        end
        if (if_s.frame_start) begin
            if (sf_per > 0 && last_fs >= 0) check("S.frame_period", 32'(cyc - last_fs), 32'(sf_per));
            last_fs = cyc;
        end
    endtask

    initial begin
        int  hs_lo, act_s;
        bit  found;
        hs_lo = 0;
        act_s = 0;
        found = 1'b0;

        // Reset held with the strobe high: reset must win.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("D.rst_x", 32'(if_d.x), 32'd799);
        check("D.rst_y", 32'(if_d.y), 32'd524);
        check("S.rst_hs", 32'(if_s.hs), 32'd0);

        // Free-running strobe: line 800, tiny frame 42.
        ls_per = 800; sf_per = 42; last_ls = -1; last_fs = -1;
        step(1'b1, 1'b1);
        check("D.first_x", 32'(if_d.x), 32'd0);
        check("D.first_y", 32'(if_d.y), 32'd0);
        check("D.first_fs", 32'(if_d.frame_start), 32'd1);
        check("D.first_fc", 32'(if_d.frame_count), 32'd1);
        act_s = int'(if_s.active);
        for (int i = 1; i < 1700; i++) begin
            step(1'b1, 1'b1);
            if (n <= 800 && !if_d.hs) hs_lo++;
            if (n <= 42 && if_s.active) act_s++;
        end
        check("D.hs_low_per_line", 32'(hs_lo), 32'd96);
        check("S.active_per_frame", 32'(act_s), 32'd12);

        // Strobe toggling every cycle: periods double.
        ls_per = 1600; sf_per = 84; last_ls = -1; last_fs = -1;
        for (int i = 0; i < 3400; i++) begin
            step(1'b1, (i % 2) == 1);
        end

        // Mid-line reset for a single cycle at x=300.
        ls_per = 0; sf_per = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(1'b1, 1'b1);
            found = (int'(if_d.x) == 300);
        end
        check("D.reach_x300", 32'(found), 32'd1);
        step(1'b0, 1'b1);
        check("D.mid_rst_x", 32'(if_d.x), 32'd799);
        check("D.mid_rst_fc", 32'(if_d.frame_count), 32'd0);
        step(1'b1, 1'b1);
        check("D.after_rst_fs", 32'(if_d.frame_start), 32'd1);
        check("S.after_rst_fc", 32'(if_s.frame_count), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/vga_timing.md
# vga_timing

Parametrised raster timing generator for the VGA output path. It replaces hard-coded 640x480 sync and blank logic with configurable porch, sync and polarity settings. It adds a pixel-enable strobe, line and frame markers, a frame counter, and a configurable delay line so sync and blank stay aligned with a pipelined pixel generator. It sits between the clock or reset inputs and the game or pixel logic, which consumes `x`, `y` and `active` and drives the colour outputs alongside `hs_d`, `vs_d` and `blank_d`.

## Interface
- `H_VISIBLE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_VISIBLE`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `HS_POL`, 0: asserted level of `hs` and `hs_d` (0 = active-low)
- `VS_POL`, 0: asserted level of `vs` and `vs_d`
- `PIPE`, 1: delay of `hs_d`, `vs_d` and `blank_d`, in pixel strobes; legal range 0..7
- `CW`, 10: width of the `x` and `y` counters
- `FRAME_W`, 8: width of the frame counter

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset. Synchronous, active-low.
- `pix_en` in 1: pixel strobe. All counting and shifting happens only on cycles where it is 1.
- `x` out CW: horizontal position, 0..H_TOTAL-1
- `y` out CW: vertical position, 0..V_TOTAL-1
- `active` out 1: current (`x`,`y`) is in the visible area
- `hs` out 1: horizontal sync, aligned with `x`
- `vs` out 1: vertical sync, aligned with `y`
- `line_start` out 1: one-cycle pulse when `x` becomes 0
- `frame_start` out 1: one-cycle pulse when (`x`,`y`) becomes (0,0)
- `frame_count` out FRAME_W: number of completed frame starts, modulo 2^FRAME_W
- `hs_d` out 1: `hs` delayed by PIPE strobes
- `vs_d` out 1: `vs` delayed by PIPE strobes
- `blank_d` out 1: `!active` delayed by PIPE strobes

## Operation
- Totals:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800).
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 525).
- CW must hold H_TOTAL-1 and V_TOTAL-1. The simulation elaboration check fails if it does not, or if PIPE is outside 0..7.
- Counting on a cycle with `pix_en`=1:
  - `x` advances by 1 and wraps from H_TOTAL-1 to 0.
  - On each wrap of `x`, `y` advances by 1 and wraps from V_TOTAL-1 to 0.
- Decode, all registered and describing the same pixel as the current `x`/`y`:
  - `active` = (x < H_VISIBLE) && (y < V_VISIBLE).
  - `hs` is at HS_POL when H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC, and at !HS_POL otherwise.
  - `vs` is at VS_POL when V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC, and at !VS_POL otherwise. `vs` is decoded per line: it changes only together with `y`.
- Markers:
  - `line_start` is 1 only in the cycle after a strobe that moved `x` to 0. This includes lines in vertical blanking.
  - `frame_start` behaves the same way for (0,0).
  - Both are 0 on any cycle following `pix_en`=0.
- `frame_count` increments in the same cycle `frame_start` is 1. It wraps silently.
- Delay line:
  - A PIPE-deep shift register of {hs, vs, !active} that shifts only on `pix_en`.
  - PIPE=0 makes `hs_d`/`vs_d`/`blank_d` combinational copies of `hs`/`vs`/`!active`.

## Timing
- All state updates on the rising edge of `clk`. No combinational path from `pix_en` to any output except through registers.
- Reset (`rst_n`=0 at an edge) sets:
  - `x`=H_TOTAL-1, `y`=V_TOTAL-1
  - `active`=0, `hs`=!HS_POL, `vs`=!VS_POL
  - `line_start`=0, `frame_start`=0, `frame_count`=0
  - every delay stage to {!HS_POL, !VS_POL, 1}
- Reset overrides `pix_en` and applies mid-frame with no partial-line completion.
- First strobe after reset release produces `x`=0, `y`=0, `active`=1, `line_start`=1, `frame_start`=1. `frame_count` becomes 1 on that same strobe.
- Latency from a strobe to the updated `x`/`y`/`active`/`hs`/`vs`: 1 clk.
- `hs_d`, `vs_d` and `blank_d` lag the undelayed signals by exactly PIPE strobes, not PIPE clocks.
- With `pix_en` held at 1 and default parameters:
  - line period = 800 clk
  - frame period = 420000 clk

## Test plan
- Defaults, `pix_en`=1, release reset. Required:
  - first edge gives (0,0) with `frame_start`=1 and `frame_count`=1
  - `line_start` every 800 cycles
  - `frame_start` every 420000 cycles
- Defaults. Required:
  - `hs`=0 exactly for x=656..751 (96 cycles per line), 1 elsewhere
  - `vs`=0 exactly for y=490..491
  - `active`=1 count per frame = 307200
- `pix_en` toggling 1/0 every cycle. Required:
  - line period = 1600 clk
  - `x` holds on every 0 cycle
  - `line_start` and `frame_start` stay single-cycle pulses
- PIPE=3. Required:
  - `blank_d` falls 3 strobes after `active` rises at (0,0)
  - `hs_d` edges trail `hs` edges by 3 strobes
  - with PIPE=0, `blank_d` == `!active` on every cycle
- H=4/1/1/1, V=3/1/1/1, HS_POL=1, FRAME_W=2, exhaustive over 8 frames. Required:
  - `hs`=1 only at x=5
  - `vs`=0 only at y=4
  - `frame_count` sequence 1,2,3,0,1,…
- `rst_n`=0 for 1 cycle at x=300, y=200 with `pix_en`=1. Required:
  - next edge shows all reset values
  - following strobe gives (0,0) and `frame_start`=1
